// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write integer register file with a
// per-register busy scoreboard and optional write-to-read bypass.
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   w_en, rd_addr, rd      writeback port (also clears the busy bit)
//   r1_addr, r2_addr       read addresses
//   r1_out, r2_out         combinational read data
//   r1_busy, r2_busy       combinational busy bits of the read addresses
//   iss_en, iss_addr       issue port (sets the busy bit)
//   busy_cnt               registered count of busy registers
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd,
  input  logic [AW-1:0]   r1_addr,
  input  logic [AW-1:0]   r2_addr,
  output logic [XLEN-1:0] r1_out,
  output logic [XLEN-1:0] r2_out,
  output logic            r1_busy,
  output logic            r2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic set_ok;
  logic clr_ok;
  logic same;
  logic inc;
  logic dec;

  assign set_ok = iss_en && (iss_addr != '0);
  assign clr_ok = w_en && (rd_addr != '0);
  assign same   = set_ok && clr_ok && (iss_addr == rd_addr);

  // A new producer on the completing register keeps it busy, so that
  // case never decrements.
  assign inc = set_ok && !busy[iss_addr];
  assign dec = clr_ok && busy[rd_addr] && !same;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '{default: '0};
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (clr_ok) begin
        regs[rd_addr] <= rd;
        busy[rd_addr] <= 1'b0;
      end
      // Placed after the clear so issue wins on the same address.
      if (set_ok) begin
        busy[iss_addr] <= 1'b1;
      end
      if (inc && !dec) begin
        busy_cnt <= busy_cnt + 1'b1;
      end else if (dec && !inc) begin
        busy_cnt <= busy_cnt - 1'b1;
      end
    end
  end

  logic hit1;
  logic hit2;
  logic keep1;
  logic keep2;

  assign hit1  = (BYPASS != 0) && clr_ok && (r1_addr == rd_addr);
  assign hit2  = (BYPASS != 0) && clr_ok && (r2_addr == rd_addr);
  assign keep1 = set_ok && (iss_addr == r1_addr);
  assign keep2 = set_ok && (iss_addr == r2_addr);

  always_comb begin
    r1_out  = '0;
    r1_busy = 1'b0;
    if (r1_addr != '0) begin
      r1_out  = hit1 ? rd : regs[r1_addr];
      r1_busy = (hit1 && !keep1) ? 1'b0 : busy[r1_addr];
    end
  end

  always_comb begin
    r2_out  = '0;
    r2_busy = 1'b0;
    if (r2_addr != '0) begin
      r2_out  = hit2 ? rd : regs[r2_addr];
      r2_busy = (hit2 && !keep2) ? 1'b0 : busy[r2_addr];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector table plus hand sequences against two instances,
// one with bypass and one without, checked through an expectation queue.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst, w_en, iss_en;
  logic [AW-1:0]   rd_addr, r1_addr, r2_addr, iss_addr;
  logic [XLEN-1:0] rd;

  logic [XLEN-1:0] r1b, r2b, r1n, r2n;
  logic            b1b, b2b, b1n, b2n;
  logic [AW:0]     cntb, cntn;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .w_en(w_en), .rd_addr(rd_addr), .rd(rd),
    .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_out(r1b), .r2_out(r2b), .r1_busy(b1b), .r2_busy(b2b),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cntb)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .w_en(w_en), .rd_addr(rd_addr), .rd(rd),
    .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_out(r1n), .r2_out(r2n), .r1_busy(b1n), .r2_busy(b2n),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cntn)
  );

  typedef struct {
    int          id;
    logic        rst, w_en, iss_en;
    logic [4:0]  rd_addr, iss_addr, r1a, r2a;
    logic [31:0] rd;
    logic        chk;
    logic [31:0] e_r1, e_r2;
    logic        e_b1, e_b2;
    logic [5:0]  e_cnt;
    logic [31:0] e_r1n;
    logic        e_b1n;
  } vec_t;

  vec_t tbl[$];
  vec_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row   = 0;

  function automatic vec_t mk(
    input logic r, input logic w, input logic [4:0] ra,
    input logic [31:0] d, input logic is, input logic [4:0] ia,
    input logic [4:0] a1, input logic [4:0] a2, input logic c,
    input logic [31:0] er1, input logic [31:0] er2,
    input logic eb1, input logic eb2, input logic [5:0] ec,
    input logic [31:0] er1n, input logic eb1n);
    vec_t v;
    v.id = 0;
    v.rst = r; v.w_en = w; v.rd_addr = ra; v.rd = d;
    v.iss_en = is; v.iss_addr = ia; v.r1a = a1; v.r2a = a2;
    v.chk = c; v.e_r1 = er1; v.e_r2 = er2;
    v.e_b1 = eb1; v.e_b2 = eb2; v.e_cnt = ec;
    v.e_r1n = er1n; v.e_b1n = eb1n;
    return v;
  endfunction

  task automatic check(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      vec_t e;
      e = expq.pop_front();
      if (e.chk) begin
        check("r1_out",   e.id, r1b, e.e_r1);
        check("r2_out",   e.id, r2b, e.e_r2);
        check("r1_busy",  e.id, {31'd0, b1b}, {31'd0, e.e_b1});
        check("r2_busy",  e.id, {31'd0, b2b}, {31'd0, e.e_b2});
        check("busy_cnt", e.id, {26'd0, cntb}, {26'd0, e.e_cnt});
        check("nb_r1",    e.id, r1n, e.e_r1n);
        check("nb_busy1", e.id, {31'd0, b1n}, {31'd0, e.e_b1n});
        check("nb_cnt",   e.id, {26'd0, cntn}, {26'd0, e.e_cnt});
      end
    end
  end

  // Drive one cycle shortly after the rising edge; its expectation
  // is checked on the following falling edge.
  task automatic cycle(input vec_t v);
    @(posedge clk);
    #1;
    v.id     = row;
    row++;
    rst      = v.rst;
    w_en     = v.w_en;
    rd_addr  = v.rd_addr;
    rd       = v.rd;
    iss_en   = v.iss_en;
    iss_addr = v.iss_addr;
    r1_addr  = v.r1a;
    r2_addr  = v.r2a;
    expq.push_back(v);
  endtask

  logic [31:0] wv [8];

  initial begin
    rst = 1'b1; w_en = 1'b0; iss_en = 1'b0;
    rd_addr = '0; rd = '0; iss_addr = '0;
    r1_addr = '0; r2_addr = '0;
    wv[1] = 32'hfefe; wv[2] = 32'habba; wv[3] = 32'h1313;
    wv[4] = 32'hbadd; wv[5] = 32'heafd; wv[6] = 32'hbbbb;
    wv[7] = 32'h6969;

    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,2,1, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,32'hfefe,0,0,2,3,1, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,0,1, 32'hfefe,0,0,0,0, 32'hfefe,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1, 0,0,0,0,0, 0,0));
    for (int i = 1; i <= 7; i++) begin
      tbl.push_back(mk(0,1,5'(i),wv[i],0,0,5'(i),0,1,
                       wv[i],0,0,0,0, 0,0));
    end
    tbl.push_back(mk(0,0,0,0,0,0,1,2,1,
                     32'hfefe,32'habba,0,0,0, 32'hfefe,0));
    tbl.push_back(mk(0,0,0,0,0,0,3,4,1,
                     32'h1313,32'hbadd,0,0,0, 32'h1313,0));
    tbl.push_back(mk(0,0,0,0,0,0,7,7,1,
                     32'h6969,32'h6969,0,0,0, 32'h6969,0));
    tbl.push_back(mk(0,1,0,32'hdeadbeef,1,0,0,0,1, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,5,1, 0,32'heafd,0,0,0, 0,0));
    tbl.push_back(mk(0,1,5,32'h1234,0,0,5,5,1,
                     32'h1234,32'h1234,0,0,0, 32'heafd,0));
    tbl.push_back(mk(0,0,0,0,1,3,5,3,1,
                     32'h1234,32'h1313,0,0,0, 32'h1234,0));
    tbl.push_back(mk(0,0,0,0,1,4,3,4,1,
                     32'h1313,32'hbadd,1,0,1, 32'h1313,1));
    tbl.push_back(mk(0,1,3,32'h3333,0,0,3,4,1,
                     32'h3333,32'hbadd,0,1,2, 32'h1313,1));
    tbl.push_back(mk(0,1,4,32'h4444,1,4,3,4,1,
                     32'h3333,32'h4444,0,1,1, 32'h3333,0));
    tbl.push_back(mk(0,1,4,32'h5555,1,6,4,6,1,
                     32'h5555,32'hbbbb,0,0,1, 32'h4444,1));
    tbl.push_back(mk(0,0,0,0,0,0,6,4,1,
                     32'hbbbb,32'h5555,1,0,1, 32'hbbbb,1));
    tbl.push_back(mk(1,1,2,32'haaaa,1,2,6,0,1,
                     32'hbbbb,0,1,0,1, 32'hbbbb,1));
    tbl.push_back(mk(0,0,0,0,0,0,2,6,1, 0,0,0,0,0, 0,0));

    foreach (tbl[k]) cycle(tbl[k]);

    // Fill every register's busy bit, reissue one, then drain.
    for (int i = 1; i < NREGS; i++) begin
      cycle(mk(0,0,0,0,1,5'(i),5'(i),0,1, 0,0,0,0,6'(i-1), 0,0));
    end
    cycle(mk(0,0,0,0,1,5,5,0,1, 0,0,1,0,31, 0,1));
    cycle(mk(0,0,0,0,0,0,5,0,1, 0,0,1,0,31, 0,1));
    for (int i = 1; i < NREGS; i++) begin
      cycle(mk(0,1,5'(i),32'(i),0,0,5'(i),0,1,
               32'(i),0,0,0,6'(32-i), 0,1));
    end
    cycle(mk(0,0,0,0,0,0,1,0,1, 32'd1,0,0,0,0, 32'd1,0));

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d left want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's 2-read/1-write integer register file. It generalises data width and register count, and adds synchronous reset clearing and optional write-to-read bypass. It also adds a per-register scoreboard: busy bits are set when a producing instruction issues and cleared on its writeback. It sits between decode/issue (read ports, issue port) and writeback (write port) of the pipelined core.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2); AW = $clog2(NREGS)
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
w_en  input  1  writeback enable
rd_addr  input  AW  writeback register address
rd  input  XLEN  writeback data
r1_addr  input  AW  read port 1 address
r2_addr  input  AW  read port 2 address
r1_out  output  XLEN  read port 1 data (combinational)
r2_out  output  XLEN  read port 2 data (combinational)
r1_busy  output  1  scoreboard bit of r1_addr (combinational)
r2_busy  output  1  scoreboard bit of r2_addr (combinational)
iss_en  input  1  issue: mark iss_addr as having a pending producer
iss_addr  input  AW  destination register of the issuing instruction
busy_cnt  output  AW+1  number of registers currently busy (registered)

Behaviour:
- Reset: on a rising clk with rst=1, all registers are set to 0, all busy bits to 0, and busy_cnt to 0. rst overrides w_en and iss_en in the same cycle. Outputs reflect the cleared state in the cycle after the reset edge.
- Register 0: always reads 0 and is never busy. Writes and issues to address 0 are ignored and do not change busy_cnt.
- Write: on a rising clk with w_en=1, rd_addr!=0 and rst=0, registers[rd_addr] <= rd. Write latency is 1 cycle.
- Read: r1_out/r2_out are combinational on the address and register contents. Both ports may address the same register.
- Bypass (BYPASS=1): if w_en=1, rd_addr!=0 and rN_addr==rd_addr, then rN_out=rd in that same cycle.
- No bypass (BYPASS=0): the new value becomes visible the cycle after the write edge.
- Scoreboard:
  - iss_en=1 with iss_addr!=0 sets busy[iss_addr] at the edge.
  - w_en=1 with rd_addr!=0 clears busy[rd_addr] at the edge.
  - Same address in the same cycle: issue wins, the bit stays or ends 1 (a new producer supersedes the completing one). The write data is still committed.
  - Issuing a register that is already busy leaves it busy, with no count change.
  - Writing a register that is not busy is legal and leaves busy 0.
- rN_busy: combinational view of the busy bit for rN_addr. With BYPASS=1, rN_busy is forced 0 when a same-cycle write to that address clears it and no issue to it occurs in the same cycle. With BYPASS=0 it shows the registered bit.
- busy_cnt: registered population count of the busy bits, updated on the same edge as the bits.
  - Per cycle the net change is -1, 0 or +1; set and clear on different addresses together give net 0.
  - It never exceeds NREGS-1 and never wraps.
- Reset mid-operation: a write or issue in the reset cycle is discarded. There are no partial effects.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset clear: write 0xfefe to x1, then assert rst for 1 cycle -> r1_addr=1 reads 0x00000000, r1_busy=0, busy_cnt=0.
- Sequential write/readback: write 0xfefe, 0xabba, 0x1313, 0xbadd, 0xeafd, 0xbbbb, 0x6969 to x1..x7 on consecutive cycles -> r1/r2 read pairs (1,2)=(fefe,abba), (3,4)=(1313,badd), (7,7)=(6969,6969).
- x0 invariance: w_en with rd_addr=0, rd=0xdeadbeef, plus iss_en with iss_addr=0 -> r1_addr=0 reads 0, r1_busy=0, busy_cnt unchanged.
- Bypass: BYPASS=1, write 0x1234 to x5 while r1_addr=5 -> r1_out=0x1234 in the same cycle. With BYPASS=0, the old value is seen that cycle and 0x1234 the next.
- Scoreboard:
  - Issue x3, then x4 -> busy_cnt=2 and r1_busy(3)=1.
  - Write x3 -> busy_cnt=1.
  - Issue x4 and write x4 in the same cycle -> x4 stays busy, data committed, busy_cnt=1.
  - Issue x6 while writing x4 -> busy_cnt=1.
- Reset priority: rst=1 together with w_en (x2=0xaaaa) and iss_en (x2) -> x2=0, not busy, busy_cnt=0.
